cache_write_buffer: RTL and testbench
=====================================

# cache_write_buffer

Posted write buffer between the direct-mapped `Cache` and the block-wide data memory. Dirty-line evictions from the cache are queued in a small FIFO and drained to memory when the memory port is otherwise idle, so an eviction no longer sits in series with the refill read. Line reads that match a queued line are forwarded from the buffer. Reads that miss the buffer go to memory ahead of pending drains.

## Interface

**Parameters**
- `LINE_SIZE`, default 16: line size in bytes; data width is `LINE_SIZE*8`.
- `DEPTH`, default 4: number of buffered lines; must be a power of two, at least 2.
- `ADDR_W`, default 32: width of the block address, already shifted by `CLOG2(LINE_SIZE)`.

**Ports**
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high reset.
- `req_valid`, input, 1: cache request valid.
- `req_read`, input, 1: line read (refill).
- `req_write`, input, 1: line write (eviction); exactly one of `req_read`/`req_write` is high with `req_valid`.
- `req_addr`, input, `ADDR_W`: block address.
- `req_data`, input, `LINE_SIZE*8`: eviction data.
- `req_ready`, output, 1: request accepted this cycle if `req_valid` is also high.
- `resp_valid`, output, 1: one-cycle pulse carrying read data.
- `resp_data`, output, `LINE_SIZE*8`: read data.
- `mem_input_valid`, output, 1: memory request.
- `mem_read`, output, 1: memory read.
- `mem_write`, output, 1: memory write.
- `mem_addr`, output, `ADDR_W`: memory block address.
- `mem_din`, output, `LINE_SIZE*8`: memory write data.
- `mem_output_valid`, input, 1: memory read data valid.
- `mem_dout`, input, `LINE_SIZE*8`: memory read data.
- `mem_ready`, input, 1: memory idle and able to accept a request.

## Operation

**Reset**
- All outputs are 0.
- FIFO is empty: head, tail and count are 0; all entry valid bits are 0.
- State is `IDLE`.
- Reset mid-operation abandons any outstanding memory access; no response is emitted.

**Acceptance**
- `req_ready = (state==IDLE) && (count != DEPTH)`.
- `req_ready` is independent of `req_addr`.

**Write accepted**
- If a valid entry has the same address, overwrite its data; count is unchanged (coalesce).
- Otherwise push at the tail, `count+1`.

**Read accepted**
- The address is compared against all valid entries; at most one can match because of coalescing.
- Hit: `resp_data` is loaded with the entry data and `resp_valid` is high in the next cycle. State stays `IDLE`.
- Miss: latch the address and go to `RD_REQ`.

**States**
- `IDLE`: if no request is accepted and `count>0`, go to `WR_REQ`. An accepted request always wins over a drain.
- `RD_REQ`: drive `mem_input_valid=1`, `mem_read=1`, `mem_addr`=latched address. If `mem_ready`, go to `RD_WAIT`; otherwise hold.
- `RD_WAIT`: on `mem_output_valid`, register `mem_dout` into `resp_data`, pulse `resp_valid` the next cycle, and go to `IDLE`.
- `WR_REQ`: drive `mem_input_valid=1`, `mem_write=1`, `mem_addr`/`mem_din` from the head entry. If `mem_ready`, go to `WR_WAIT`.
- `WR_WAIT`: wait at least one cycle. When `mem_ready` returns high, pop the head (`count-1`) and go to `IDLE`.

**Memory-side outputs**
- All memory-side outputs are 0 outside `RD_REQ`/`WR_REQ`.

**Visibility and full buffer**
- The head entry stays valid and forwardable until its write completes.
- A full buffer deasserts `req_ready`. `IDLE` then drains because no request can be accepted, so the buffer cannot deadlock.

**Pointers**
- Pointers wrap modulo `DEPTH`.

## Timing
- Write accept: edge N; entry is visible for forwarding from cycle N+1.
- Read hit: accepted at edge N; `resp_valid` in cycle N+1.
- Read miss with memory ready: memory request in cycle N+1; `resp_valid` in the cycle after `mem_output_valid`. Added latency is 2 cycles plus memory latency.
- Drain: starts one cycle after an idle cycle with `count>0`; the pop happens at the edge where `mem_ready` rises in `WR_WAIT`.
- `req_ready` is combinational from state and count only.
- `resp_valid` and `resp_data` are registered.

## Structure
- Shared constants in the existing `Constants.v`: `WB_DEPTH`, and the state encodings `WB_IDLE`, `WB_RD_REQ`, `WB_RD_WAIT`, `WB_WR_REQ`, `WB_WR_WAIT` (3-bit).
- Use `CLOG2.v` for pointer widths.
- One sub-module, `wb_match`: parallel address compare over `DEPTH` entries, producing `hit` and the one-hot/encoded hit index.
- `Cache` drives the `req_*` ports in place of its direct `DataMemory` connection.

## Test plan
Bench configuration: `DEPTH=4`; the memory stub has a fixed latency of 4 cycles.
1. Reset with `req_valid=1` -> all outputs 0, `req_ready=0` during reset, then 1.
2. Write 0x10 with data A, then read 0x10 the next cycle -> `resp_valid` one cycle after the read accept, `resp_data=A`, no memory access.
3. Write 0x10=A, then write 0x10=B -> count stays 1; the later drain writes B to 0x10 exactly once.
4. Four writes 0x1..0x4 -> `req_ready=0` on the fifth; memory writes occur in order 0x1..0x4; `req_ready` returns after the first pop.
5. Two queued writes plus a read of 0x20 (miss) while `IDLE` -> memory read of 0x20 is issued before either write; `resp_data` equals memory contents at 0x20.
6. Reset asserted during `WR_WAIT` -> state `IDLE`, count 0, no `resp_valid`, no further `mem_input_valid`.

Source files
------------

// File: rtl/cache_write_buffer_pkg.sv
// Shared constants for the posted cache write buffer:
// default depth and the 3-bit controller state encodings.
package cache_write_buffer_pkg;

    localparam int WB_DEPTH = 4;

    localparam logic [2:0] WB_IDLE    = 3'd0;
    localparam logic [2:0] WB_RD_REQ  = 3'd1;
    localparam logic [2:0] WB_RD_WAIT = 3'd2;
    localparam logic [2:0] WB_WR_REQ  = 3'd3;
    localparam logic [2:0] WB_WR_WAIT = 3'd4;

endpackage

// File: rtl/cache_write_buffer_match.sv
// wb_match: parallel block-address compare across all buffer entries.
// Ports: addr, entry_addr (packed per entry), entry_valid -> hit, hit_onehot, hit_idx.
module wb_match #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DEPTH*ADDR_W-1:0] entry_addr,
    input  logic [DEPTH-1:0]        entry_valid,
    output logic                    hit,
    output logic [DEPTH-1:0]        hit_onehot,
    output logic [IDX_W-1:0]        hit_idx
);

    always_comb begin
        hit_onehot = '0;
        hit_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_onehot[i] = entry_valid[i] &&
                (entry_addr[i*ADDR_W +: ADDR_W] == addr);
            // Coalescing keeps at most one match, so OR-encoding is exact.
            if (hit_onehot[i])
                hit_idx = hit_idx | IDX_W'(i);
        end
        hit = |hit_onehot;
    end

endmodule

// File: rtl/cache_write_buffer.sv
// Posted write buffer between the cache and block-wide data memory.
// Ports: req_* (cache side), resp_* (read data), mem_* (memory side).
module cache_write_buffer
    import cache_write_buffer_pkg::*;
#(
    parameter int LINE_SIZE = 16,
    parameter int DEPTH     = WB_DEPTH,
    parameter int ADDR_W    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic                   req_read,
    input  logic                   req_write,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [LINE_SIZE*8-1:0] req_data,
    output logic                   req_ready,
    output logic                   resp_valid,
    output logic [LINE_SIZE*8-1:0] resp_data,
    output logic                   mem_input_valid,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [LINE_SIZE*8-1:0] mem_din,
    input  logic                   mem_output_valid,
    input  logic [LINE_SIZE*8-1:0] mem_dout,
    input  logic                   mem_ready
);

    localparam int DW = LINE_SIZE * 8;
    localparam int PW = $clog2(DEPTH);

    logic [2:0]                  state;
    logic [PW-1:0]               head;
    logic [PW-1:0]               tail;
    logic [PW:0]                 count;
    logic [DEPTH-1:0]            ent_vld;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
    logic [DEPTH-1:0][DW-1:0]    ent_data;
    logic [ADDR_W-1:0]           rd_addr;

    logic             hit;
    logic [DEPTH-1:0] hit_onehot;
    logic [PW-1:0]    hit_idx;
    logic [DW-1:0]    hit_data;
    logic             accept;
    logic             in_rd_req;
    logic             in_wr_req;

    wb_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .IDX_W  (PW)
    ) u_match (
        .addr        (req_addr),
        .entry_addr  (ent_addr),
        .entry_valid (ent_vld),
        .hit         (hit),
        .hit_onehot  (hit_onehot),
        .hit_idx     (hit_idx)
    );

    always_comb begin
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++)
            if (hit_onehot[i])
                hit_data = hit_data | ent_data[i];
    end

    // Gated by reset so every output reads 0 while reset is held.
    assign req_ready = !reset && (state == WB_IDLE) &&
                       (count != (PW+1)'(DEPTH));
    assign accept    = req_valid && req_ready;

    assign in_rd_req = !reset && (state == WB_RD_REQ);
    assign in_wr_req = !reset && (state == WB_WR_REQ);

    assign mem_input_valid = in_rd_req || in_wr_req;
    assign mem_read        = in_rd_req;
    assign mem_write       = in_wr_req;
    assign mem_addr        = in_rd_req ? rd_addr :
                             in_wr_req ? ent_addr[head] : '0;
    assign mem_din         = in_wr_req ? ent_data[head] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WB_IDLE;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            ent_vld    <= '0;
            rd_addr    <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                WB_IDLE: begin
                    if (accept && req_write) begin
                        if (hit) begin
                            ent_data[hit_idx] <= req_data;
                        end else begin
                            ent_addr[tail] <= req_addr;
                            ent_data[tail] <= req_data;
                            ent_vld[tail]  <= 1'b1;
                            tail           <= tail + 1'b1;
                            count          <= count + 1'b1;
                        end
                    end else if (accept && req_read) begin
                        if (hit) begin
                            resp_data  <= hit_data;
                            resp_valid <= 1'b1;
                        end else begin
                            rd_addr <= req_addr;
                            state   <= WB_RD_REQ;
                        end
                    end else if (!accept && count != '0) begin
                        state <= WB_WR_REQ;
                    end
                end
                WB_RD_REQ: begin
                    if (mem_ready)
                        state <= WB_RD_WAIT;
                end
                WB_RD_WAIT: begin
                    if (mem_output_valid) begin
                        resp_data  <= mem_dout;
                        resp_valid <= 1'b1;
                        state      <= WB_IDLE;
                    end
                end
                WB_WR_REQ: begin
                    if (mem_ready)
                        state <= WB_WR_WAIT;
                end
                WB_WR_WAIT: begin
                    // Head stays forwardable until memory finishes it.
                    if (mem_ready) begin
                        ent_vld[head] <= 1'b0;
                        head          <= head + 1'b1;
                        count         <= count - 1'b1;
                        state         <= WB_IDLE;
                    end
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_write_buffer.sv
// Directed bench for cache_write_buffer with a 4-cycle memory stub.
// Ports: drives all DUT inputs; stub logs every memory request in order.
module tb_cache_write_buffer;

    localparam int LS = 16;
    localparam int DW = LS * 8;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_read = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_data = '0;
    logic          req_ready;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic          mem_input_valid;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_output_valid = 1'b0;
    logic [DW-1:0] mem_dout = '0;
    logic          mem_ready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cache_write_buffer #(
        .LINE_SIZE (LS),
        .DEPTH     (4),
        .ADDR_W    (AW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_read         (req_read),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .resp_valid       (resp_valid),
        .resp_data        (resp_data),
        .mem_input_valid  (mem_input_valid),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_addr         (mem_addr),
        .mem_din          (mem_din),
        .mem_output_valid (mem_output_valid),
        .mem_dout         (mem_dout),
        .mem_ready        (mem_ready)
    );

    // Memory stub: fixed 4-cycle latency, ready only when idle.
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [3:0]    busy = '0;
    logic          p_wr = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_data = '0;
    logic          log_wr [$];
    logic [AW-1:0] log_addr [$];
    logic [DW-1:0] log_data [$];

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {4{a ^ 32'hA5A5_0000}};
    endfunction

    assign mem_ready = (busy == 4'd0);

    always @(posedge clk) begin
        mem_output_valid <= 1'b0;
        if (busy == 4'd0) begin
            if (mem_input_valid) begin
                busy   <= 4'd4;
                p_wr   <= mem_write;
                p_addr <= mem_addr;
                p_data <= mem_din;
                log_wr.push_back(mem_write);
                log_addr.push_back(mem_addr);
                log_data.push_back(mem_din);
            end
        end else begin
            busy <= busy - 4'd1;
            if (busy == 4'd1) begin
                if (p_wr) begin
                    mem[p_addr] = p_data;
                end else begin
                    mem_output_valid <= 1'b1;
                    mem_dout <= mem.exists(p_addr) ? mem[p_addr]
                                                   : init_val(p_addr);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        log_wr.delete();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic send(input logic rd, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        int t = 0;
        req_valid = 1'b1;
        req_read  = rd;
        req_write = !rd;
        req_addr  = a;
        req_data  = d;
        while (!req_ready && t < 200) begin
            step();
            t++;
        end
        if (t >= 200)
            chk("send_timeout", 0, 1);
        step();
        req_valid = 1'b0;
        req_read  = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic wait_resp(input string tag);
        int t = 0;
        while (!resp_valid && t < 100) begin
            step();
            t++;
        end
        chk(tag, resp_valid, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step();
    endtask

    logic [DW-1:0] da, db, d40;
    logic          saw_mem, saw_resp;

    initial begin
        da  = {4{32'h1111_AAAA}};
        db  = {4{32'h2222_BBBB}};
        d40 = {4{32'h4040_4040}};

        // 1: reset with a pending request
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h99;
        step();
        step();
        chk("rst_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_mem_valid", mem_input_valid, 0);
        chk("rst_mem_rw", {mem_read, mem_write}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);
        req_valid = 1'b0;
        req_write = 1'b0;
        reset = 1'b0;
        step();
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_log", log_wr.size(), 0);

        // 2: write then read hit, forwarded without memory
        send(1'b0, 32'h10, da);
        send(1'b1, 32'h10, '0);
        chk("hit_resp_valid", resp_valid, 1);
        chk("hit_resp_data", resp_data, da);
        chk("hit_no_mem", mem_input_valid, 0);
        chk("hit_log_empty", log_wr.size(), 0);
        step();
        chk("hit_pulse", resp_valid, 0);
        idle(30);
        chk("d2_count", log_wr.size(), 1);
        chk("d2_wr", log_wr[0], 1);
        chk("d2_addr", log_addr[0], 32'h10);
        chk("d2_data", log_data[0], da);
        clear_log();

        // 3: coalesce two writes to one line
        send(1'b0, 32'h10, da);
        send(1'b0, 32'h10, db);
        idle(30);
        chk("coal_count", log_wr.size(), 1);
        chk("coal_addr", log_addr[0], 32'h10);
        chk("coal_data", log_data[0], db);
        chk("coal_mem", mem[32'h10], db);
        clear_log();

        // 4: fill, backpressure, ordered drain
        for (int i = 1; i <= 4; i++)
            send(1'b0, AW'(i), {4{32'(i)}});
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h5;
        req_data  = {4{32'h5}};
        chk("full_ready", req_ready, 0);
        begin
            int t = 0;
            while (!req_ready && t < 100) begin
                step();
                t++;
            end
            chk("full_ready_back", req_ready, 1);
            chk("full_pop_log", log_wr.size(), 1);
            chk("full_first_done", mem[32'h1], {4{32'h1}});
        end
        step();
        req_valid = 1'b0;
        req_write = 1'b0;
        idle(60);
        chk("fill_count", log_wr.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("fill_order%0d", i), log_addr[i], AW'(i + 1));
        clear_log();

        // 5: read miss overtakes queued drains
        send(1'b0, 32'h30, da);
        send(1'b0, 32'h31, db);
        send(1'b1, 32'h20, '0);
        wait_resp("miss_resp_valid");
        chk("miss_resp_data", resp_data, init_val(32'h20));
        chk("miss_first_rd", log_wr[0], 0);
        chk("miss_first_addr", log_addr[0], 32'h20);
        idle(60);
        chk("miss_count", log_wr.size(), 3);
        chk("miss_wr1", log_addr[1], 32'h30);
        chk("miss_wr2", log_addr[2], 32'h31);
        clear_log();

        // 6: reset during WR_WAIT
        send(1'b0, 32'h40, d40);
        begin
            int t = 0;
            while (!mem_write && t < 20) begin
                step();
                t++;
            end
            chk("wr_req_seen", mem_write, 1);
        end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        saw_mem  = 1'b0;
        saw_resp = 1'b0;
        for (int i = 0; i < 30; i++) begin
            saw_mem  = saw_mem | mem_input_valid;
            saw_resp = saw_resp | resp_valid;
            step();
        end
        chk("rst6_no_mem", saw_mem, 0);
        chk("rst6_no_resp", saw_resp, 0);
        chk("rst6_ready", req_ready, 1);
        chk("rst6_log", log_wr.size(), 1);
        send(1'b1, 32'h40, '0);
        chk("rst6_miss", resp_valid, 0);
        wait_resp("rst6_resp_valid");
        chk("rst6_rd_logged", log_wr.size(), 2);
        chk("rst6_rd_addr", log_addr[1], 32'h40);
        chk("rst6_rd_data", resp_data, d40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
